// File: rtl/teclado_clave.sv
// Keypad PIN collector for the parking-gate controller: gathers up to four BCD
// digits while a vehicle is present and presents them as a 16-bit PIN on ENTER.
module teclado_clave #(
  parameter int unsigned TIMEOUT_CICLOS = 200,
  parameter int unsigned ANCHO_TIMER    = 8,
  parameter logic [3:0]  TECLA_BORRAR   = 4'hA,
  parameter logic [3:0]  TECLA_ENTER    = 4'hB
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        llegado_vehiculo,
  input  logic        tecla_valida,
  input  logic [3:0]  tecla,
  output logic [15:0] clave_ingresada,
  output logic        clave_lista,
  output logic [2:0]  digitos,
  output logic        error_tecla,
  output logic        tiempo_agotado
);

  localparam int unsigned ANCHO_CLAVE = 16;
  localparam int unsigned ANCHO_DIG   = 3;
  localparam logic [ANCHO_TIMER-1:0] TIMER_FIN = ANCHO_TIMER'(TIMEOUT_CICLOS - 1);

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    CAPTURA = 2'd1,
    LLENO   = 2'd2,
    ENVIAR  = 2'd3
  } estado_t;

  estado_t                 state_q, state_d;
  logic [ANCHO_CLAVE-1:0]  buffer_q, buffer_d;
  logic [ANCHO_CLAVE-1:0]  clave_q, clave_d;
  logic [ANCHO_DIG-1:0]    digitos_q, digitos_d;
  logic [ANCHO_TIMER-1:0]  timer_q, timer_d;
  logic                    lista_q, lista_d;
  logic                    error_q, error_d;
  logic                    tiempo_q, tiempo_d;

  logic es_digito_c;
  logic es_borrar_c;
  logic es_enter_c;
  logic timer_activo_c;
  logic expira_c;

  // Key decode and inactivity-timer status
  always_comb begin
    es_digito_c    = (tecla < 4'd10);
    es_borrar_c    = (tecla == TECLA_BORRAR);
    es_enter_c     = (tecla == TECLA_ENTER);
    timer_activo_c = ((state_q == CAPTURA) || (state_q == LLENO)) && (digitos_q != 3'd0);
    expira_c       = timer_activo_c && !tecla_valida && (timer_q == TIMER_FIN);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    buffer_d  = buffer_q;
    clave_d   = clave_q;
    digitos_d = digitos_q;
    timer_d   = '0;
    lista_d   = 1'b0;
    error_d   = 1'b0;
    tiempo_d  = 1'b0;

    unique case (state_q)
      ESPERA: begin
        if (llegado_vehiculo) begin
          state_d   = CAPTURA;
          buffer_d  = '0;
          digitos_d = '0;
        end
      end

      CAPTURA: begin
        if (tecla_valida) begin
          if (es_digito_c) begin
            buffer_d  = {buffer_q[11:0], tecla};
            digitos_d = digitos_q + 3'd1;
            if (digitos_q == 3'd3) begin
              state_d = LLENO;
            end
          end else if (es_borrar_c) begin
            buffer_d  = '0;
            digitos_d = '0;
          end else if (es_enter_c) begin
            // Short entry: rejected and discarded
            error_d   = 1'b1;
            buffer_d  = '0;
            digitos_d = '0;
          end else begin
            error_d = 1'b1;
          end
        end else if (expira_c) begin
          buffer_d  = '0;
          digitos_d = '0;
          tiempo_d  = 1'b1;
        end else if (timer_activo_c) begin
          timer_d = timer_q + ANCHO_TIMER'(1);
        end
      end

      LLENO: begin
        if (tecla_valida) begin
          if (es_borrar_c) begin
            buffer_d  = '0;
            digitos_d = '0;
            state_d   = CAPTURA;
          end else if (es_enter_c) begin
            // PIN and strobe become visible during the ENVIAR cycle
            state_d = ENVIAR;
            clave_d = buffer_q;
            lista_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end else if (expira_c) begin
          buffer_d  = '0;
          digitos_d = '0;
          tiempo_d  = 1'b1;
          state_d   = CAPTURA;
        end else begin
          timer_d = timer_q + ANCHO_TIMER'(1);
        end
      end

      ENVIAR: begin
        buffer_d  = '0;
        digitos_d = '0;
        state_d   = CAPTURA;
      end

      default: begin
        state_d = ESPERA;
      end
    endcase

    // Vehicle departure overrides everything, including ENTER and timeout
    if (!llegado_vehiculo && (state_q != ESPERA)) begin
      state_d   = ESPERA;
      buffer_d  = '0;
      digitos_d = '0;
      timer_d   = '0;
      clave_d   = clave_q;
      lista_d   = 1'b0;
      error_d   = 1'b0;
      tiempo_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ESPERA;
      buffer_q  <= '0;
      clave_q   <= '0;
      digitos_q <= '0;
      timer_q   <= '0;
      lista_q   <= 1'b0;
      error_q   <= 1'b0;
      tiempo_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      buffer_q  <= buffer_d;
      clave_q   <= clave_d;
      digitos_q <= digitos_d;
      timer_q   <= timer_d;
      lista_q   <= lista_d;
      error_q   <= error_d;
      tiempo_q  <= tiempo_d;
    end
  end

  assign clave_ingresada = clave_q;
  assign clave_lista     = lista_q;
  assign digitos         = digitos_q;
  assign error_tecla     = error_q;
  assign tiempo_agotado  = tiempo_q;

endmodule
